bp_update_scheduler: RTL
========================

# bp_update_scheduler

Sequences every write into the shared 2-bit-counter table bank that backs the local, global (gshare) and tournament choice predictors. Resolved branches from EX are buffered, then each is applied as read-modify-write passes over the single table port. The block yields that port to fetch-side lookups, which always have priority. It also runs a full initialization sweep after reset and on a flush request.

## Interface
- IDX_W, 8: table index width; each table holds 2^IDX_W entries.
- FIFO_DEPTH, 4: depth of the resolved-branch buffer (power of 2).

- clk  in  1  clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- res_valid  in  1  resolved branch or jump offered.
- res_ready  out  1  buffer accepts the offer.
- res_pc  in  32  PC of the resolved instruction.
- res_ghr  in  IDX_W  global history snapshot used at prediction time.
- res_taken  in  1  actual outcome.
- res_local_pred  in  1  local prediction that was made.
- res_global_pred  in  1  global prediction that was made.
- fetch_req  in  1  fetch owns the table port this cycle.
- clear_req  in  1  one-cycle pulse that flushes and reinitializes all tables.
- tbl_en  out  1  table access issued by this block.
- tbl_we  out  1  1 = write, 0 = read.
- tbl_sel  out  2  table select: 00 local, 01 global, 10 choice.
- tbl_idx  out  IDX_W  entry index.
- tbl_wdata  out  2  counter write value.
- tbl_rdata  in  2  read data, valid the cycle after a granted read.
- init_done  out  1  tables are initialized and updates are enabled.

## Operation
- **Handshake.** A push happens when res_valid & res_ready.
  - res_ready = init_done & ~full.
  - No push occurs when full, even if a pop happens in the same cycle.
- **Buffer entry.** Each entry stores lidx, gidx, taken, lc and gc.
  - lidx = res_pc[IDX_W+1:2].
  - gidx = lidx ^ res_ghr.
  - lc = (res_local_pred == res_taken).
  - gc = (res_global_pred == res_taken).
- **Grant rule.** Any access state with fetch_req=1 drives tbl_en=0 and holds its state.
- **FSM states.** BOOT, CLEAR, IDLE, RD_L, WR_L, RD_G, WR_G, RD_C, WR_C.
  - BOOT: the reset state; all outputs 0; goes to CLEAR next cycle.
  - CLEAR: one write per granted cycle, walking sel 00, 01, 10, each with idx 0 to 2^IDX_W-1.
    - wdata = 01 (weakly not-taken) for local and global, 10 (weakly prefer global) for choice.
    - After the last granted write, set init_done=1 and go to IDLE.
  - IDLE: buffer not empty goes to RD_L.
  - RD_x: issue a read of the head entry's index (choice uses lidx); on grant, go to WR_x.
  - WR_x: write the updated counter.
    - The counter source is tbl_rdata in the first WR cycle. It is latched then and reused while stalled.
- **Counter arithmetic.** Saturating 2-bit counter.
  - Local and global: taken gives min(c+1, 3); not taken gives max(c-1, 0).
  - Choice, gc & ~lc: increment (toward global).
  - Choice, lc & ~gc: decrement.
  - Choice, lc == gc: skip RD_C/WR_C entirely; WR_G is the final write.
- **Pop.** The head entry is popped in the cycle its final write is granted.
  - Next state is RD_L if the buffer is non-empty after the pop, otherwise IDLE.
  - A push in the same cycle counts as non-empty.
- **Clear request.** clear_req in any state other than BOOT has highest priority:
  - abandon the in-flight entry (no further writes),
  - empty the buffer and drop any push in that cycle,
  - set init_done=0, reset the sweep counter and enter CLEAR.
  - clear_req during CLEAR restarts the sweep.

## Timing
- **Reset values.** tbl_en=0, tbl_we=0, tbl_sel=00, tbl_idx=0, tbl_wdata=0, res_ready=0, init_done=0. Buffer empty, state BOOT.
- **Reset mid-operation.** Returns to BOOT immediately; all buffered updates are lost.
- **Clear duration.** 3·2^IDX_W granted cycles, plus one cycle per fetch_req stall.
- **Uncontested update.** Accepted at cycle t: IDLE at t+1, RD_L at t+2, WR_L t+3, RD_G t+4, WR_G t+5, RD_C t+6, WR_C t+7.
  - Pop at t+7 with the choice update, or at t+5 without it.
- **Back-to-back.** Entries cost 6 (or 4) port cycles each, with no IDLE bubble between them.
- **Outputs.** The tbl_* outputs are combinational from registered state, latched data and fetch_req.

## Structure
- **Package rv32i_types:**
  - bp_tbl_sel_t enum (BP_LOCAL, BP_GLOBAL, BP_CHOICE),
  - bp_upd_t struct for the buffer entry,
  - constants BP_CNT_INIT=2'b01 and BP_CHOICE_INIT=2'b10.
- **Sub-module bp_update_fifo:** parameterized synchronous FIFO of bp_upd_t.
  - Ports: push, pop, flush, full, empty, head.
  - Pointers carry one extra wrap bit.
- **Top level:** holds the FSM, the sweep counter and the counter arithmetic.

## Test plan
- **Reset then sweep.** Release rst_n with fetch_req=0.
  - Expect exactly 768 writes (IDX_W=8): sel 00 then 01 then 10, idx ascending, wdata 01/01/10.
  - init_done rises the cycle after the last write, and res_ready=1 after that.
- **Single update.** pc=0x0000_0010, ghr=0x05, taken=1, local_pred=0, global_pred=1, tbl_rdata=01 on every read.
  - Expect reads and writes at local idx 0x04, global idx 0x01, choice idx 0x04.
  - Write values 10, 10, 10; pop at t+7.
- **Choice skip.** Same entry with both predictions = 1: only 4 accesses, pop at WR_G, no sel=10 access.
- **Saturation.** taken=1 with rdata=11 writes 11; taken=0 with rdata=00 writes 00; choice decrement from 00 writes 00.
- **Fetch contention.** fetch_req=1 for 3 cycles during WR_G.
  - tbl_en=0 for those cycles; the state holds.
  - The write uses the rdata latched in the first WR_G cycle, not later bus values.
- **Full and clear.** Push 4 entries with fetch_req held at 1: res_ready=0 on the 5th offer.
  - Then pulse clear_req: the buffer empties, init_done=0, the sweep restarts at sel 00 idx 0, and no update writes occur.

Source files
------------

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update path.
//   bp_tbl_sel_t   : table select encoding on the shared counter-table port
//   bp_upd_t       : one buffered resolved-branch update
//   BP_CNT_INIT    : sweep value for local/global counters (weakly not-taken)
//   BP_CHOICE_INIT : sweep value for choice counters (weakly prefer global)
//   bp_sat_update  : 2-bit saturating counter step
package rv32i_types;

   // Index width the buffered entry is built for; the scheduler's IDX_W must match.
   localparam int BP_IDX_W = 8;

   typedef enum logic [1:0] {
      BP_LOCAL  = 2'b00,
      BP_GLOBAL = 2'b01,
      BP_CHOICE = 2'b10
   } bp_tbl_sel_t;

   // lc/gc record whether the local/global prediction matched the outcome.
   typedef struct packed {
      logic [BP_IDX_W-1:0] lidx;
      logic [BP_IDX_W-1:0] gidx;
      logic                taken;
      logic                lc;
      logic                gc;
   } bp_upd_t;

   localparam logic [1:0] BP_CNT_INIT    = 2'b01;
   localparam logic [1:0] BP_CHOICE_INIT = 2'b10;

   // Saturating 2-bit counter: step up when up=1, down otherwise.
   function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt, input logic up);
      logic [1:0] nxt;
      if (up) begin
         if (cnt == 2'b11) nxt = 2'b11;
         else              nxt = cnt + 2'b01;
      end else begin
         if (cnt == 2'b00) nxt = 2'b00;
         else              nxt = cnt - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO of resolved-branch updates.
//   push/pop : enqueue wdata / dequeue head (ignored when full / empty)
//   flush    : empties the FIFO, dominating push and pop
//   full/empty/count : occupancy; head : oldest entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bp_update_fifo
   import rv32i_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  bp_upd_t                  wdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output bp_upd_t                  head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   bp_upd_t     mem [DEPTH];

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush returns both pointers to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
         if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Entry storage, cleared on reset so head is never undefined.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full && !flush) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences all writes into the shared 2-bit counter table bank (local,
// gshare, tournament choice). Resolved branches are buffered and applied as
// read-modify-write passes; fetch_req always wins the port. After reset and on
// clear_req the whole bank is swept to its initial values.
//   res_*      : resolved-branch offer (valid/ready handshake)
//   fetch_req  : fetch owns the table port this cycle
//   clear_req  : flush buffer and re-run the initialization sweep
//   tbl_*      : table port (en/we/sel/idx/wdata out, rdata in one cycle after a read)
//   init_done  : sweep complete, updates accepted
module bp_update_scheduler
   import rv32i_types::*;
#(
   parameter int IDX_W      = BP_IDX_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [31:0]      res_pc,
   input  logic [IDX_W-1:0] res_ghr,
   input  logic             res_taken,
   input  logic             res_local_pred,
   input  logic             res_global_pred,
   input  logic             fetch_req,
   input  logic             clear_req,
   output logic             tbl_en,
   output logic             tbl_we,
   output logic [1:0]       tbl_sel,
   output logic [IDX_W-1:0] tbl_idx,
   output logic [1:0]       tbl_wdata,
   input  logic [1:0]       tbl_rdata,
   output logic             init_done
);

   localparam logic [3:0] ST_BOOT  = 4'd0;
   localparam logic [3:0] ST_CLEAR = 4'd1;
   localparam logic [3:0] ST_IDLE  = 4'd2;
   localparam logic [3:0] ST_RD_L  = 4'd3;
   localparam logic [3:0] ST_WR_L  = 4'd4;
   localparam logic [3:0] ST_RD_G  = 4'd5;
   localparam logic [3:0] ST_WR_G  = 4'd6;
   localparam logic [3:0] ST_RD_C  = 4'd7;
   localparam logic [3:0] ST_WR_C  = 4'd8;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   // Sweep counter = {sel, idx}; the last write is choice table, top index.
   localparam logic [IDX_W+1:0] SWEEP_LAST = {2'b10, {IDX_W{1'b1}}};
   localparam logic [IDX_W+1:0] SWEEP_ONE  = {{(IDX_W+1){1'b0}}, 1'b1};

   logic [3:0]       state;
   logic [IDX_W+1:0] sweep_cnt;
   logic [1:0]       rd_lat;
   logic             lat_valid;

   logic             grant;
   logic             upd_grant;
   logic             is_wr;
   logic             final_wr;
   logic             more_work;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [1:0]       cnt_src;
   bp_upd_t          head;
   bp_upd_t          entry;
   logic             unused_pc;

   assign unused_pc = ^{res_pc[31:IDX_W+2], res_pc[1:0]};

   assign entry.lidx  = res_pc[IDX_W+1:2];
   assign entry.gidx  = res_pc[IDX_W+1:2] ^ res_ghr;
   assign entry.taken = res_taken;
   assign entry.lc    = (res_local_pred == res_taken);
   assign entry.gc    = (res_global_pred == res_taken);

   assign grant     = ~fetch_req;
   // A clear in flight suppresses any further update access immediately.
   assign upd_grant = grant & ~clear_req;
   assign is_wr     = (state == ST_WR_L) || (state == ST_WR_G) || (state == ST_WR_C);
   // Read data is only on the bus in the first WR cycle; stalled cycles reuse the latch.
   assign cnt_src   = lat_valid ? rd_lat : tbl_rdata;
   // Final write: WR_G when the choice counter needs no change, else WR_C.
   assign final_wr  = grant & (((state == ST_WR_G) && (head.lc == head.gc)) || (state == ST_WR_C));
   assign res_ready = init_done & ~fifo_full;
   assign push      = res_valid & res_ready & ~clear_req;
   assign pop       = final_wr & ~clear_req;
   // A same-cycle push keeps the pipeline busy even if the head was the last entry.
   assign more_work = push | (fifo_count > CW'(1));

   bp_update_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (clear_req),
      .wdata (entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (head)
   );

   // Table port drive, decoded from the current state.
   always_comb begin
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_sel   = 2'b00;
      tbl_idx   = '0;
      tbl_wdata = 2'b00;
      case (state)
         ST_CLEAR: begin
            tbl_en  = grant;
            tbl_we  = 1'b1;
            tbl_sel = sweep_cnt[IDX_W+1:IDX_W];
            tbl_idx = sweep_cnt[IDX_W-1:0];
            if (sweep_cnt[IDX_W+1:IDX_W] == BP_CHOICE) tbl_wdata = BP_CHOICE_INIT;
            else                                       tbl_wdata = BP_CNT_INIT;
         end
         ST_RD_L: begin
            tbl_en  = upd_grant;
            tbl_sel = BP_LOCAL;
            tbl_idx = head.lidx;
         end
         ST_WR_L: begin
            tbl_en    = upd_grant;
            tbl_we    = 1'b1;
            tbl_sel   = BP_LOCAL;
            tbl_idx   = head.lidx;
            tbl_wdata = bp_sat_update(cnt_src, head.taken);
         end
         ST_RD_G: begin
            tbl_en  = upd_grant;
            tbl_sel = BP_GLOBAL;
            tbl_idx = head.gidx;
         end
         ST_WR_G: begin
            tbl_en    = upd_grant;
            tbl_we    = 1'b1;
            tbl_sel   = BP_GLOBAL;
            tbl_idx   = head.gidx;
            tbl_wdata = bp_sat_update(cnt_src, head.taken);
         end
         ST_RD_C: begin
            tbl_en  = upd_grant;
            tbl_sel = BP_CHOICE;
            tbl_idx = head.lidx;
         end
         ST_WR_C: begin
            // Only reached when lc != gc, so gc alone gives the direction.
            tbl_en    = upd_grant;
            tbl_we    = 1'b1;
            tbl_sel   = BP_CHOICE;
            tbl_idx   = head.lidx;
            tbl_wdata = bp_sat_update(cnt_src, head.gc);
         end
         default: begin
            tbl_en = 1'b0;
         end
      endcase
   end

   // FSM, sweep counter and init_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_BOOT;
         sweep_cnt <= '0;
         init_done <= 1'b0;
      end else if (clear_req && (state != ST_BOOT)) begin
         state     <= ST_CLEAR;
         sweep_cnt <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state     <= ST_CLEAR;
               sweep_cnt <= '0;
            end
            ST_CLEAR: begin
               if (grant) begin
                  if (sweep_cnt == SWEEP_LAST) begin
                     init_done <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     sweep_cnt <= sweep_cnt + SWEEP_ONE;
                  end
               end
            end
            ST_IDLE: if (!fifo_empty) state <= ST_RD_L;
            ST_RD_L: if (grant) state <= ST_WR_L;
            ST_WR_L: if (grant) state <= ST_RD_G;
            ST_RD_G: if (grant) state <= ST_WR_G;
            ST_WR_G: begin
               if (grant) begin
                  if (head.lc != head.gc) state <= ST_RD_C;
                  else if (more_work)     state <= ST_RD_L;
                  else                    state <= ST_IDLE;
               end
            end
            ST_RD_C: if (grant) state <= ST_WR_C;
            ST_WR_C: begin
               if (grant) begin
                  if (more_work) state <= ST_RD_L;
                  else           state <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_BOOT;
               init_done <= 1'b0;
            end
         endcase
      end
   end

   // Capture read data in the first WR cycle so a fetch stall cannot corrupt it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_lat    <= 2'b00;
         lat_valid <= 1'b0;
      end else if (clear_req || !is_wr) begin
         lat_valid <= 1'b0;
      end else if (grant) begin
         lat_valid <= 1'b0;
      end else if (!lat_valid) begin
         rd_lat    <= tbl_rdata;
         lat_valid <= 1'b1;
      end
   end

endmodule
